// File: rtl/fib_pkg.sv
// Shared types and default sizes for the Fibonacci request sequencer.
package fib_pkg;

  localparam int FIB_WIDTH = 8;
  localparam int FIB_IDXW  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/fib_step.sv
// Fibonacci term register pair with one adder; tracks whether each held term
// has exceeded the datapath width.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] a,
  output logic             ovf_a
);

  logic [WIDTH-1:0] b;
  logic             ovf_b;
  logic [WIDTH:0]   sum_full;

  assign sum_full = {1'b0, a} + {1'b0, b};

  // Overflow is sticky: once a term is too wide, every later term is too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a     <= '0;
      b     <= WIDTH'(1);
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (load) begin
      a     <= '0;
      b     <= WIDTH'(1);
      ovf_a <= 1'b0;
      ovf_b <= 1'b0;
    end else if (step) begin
      a     <= b;
      b     <= sum_full[WIDTH-1:0];
      ovf_a <= ovf_b;
      ovf_b <= ovf_b | ovf_a | sum_full[WIDTH];
    end
  end

endmodule

// File: rtl/fib_sequencer.sv
// Round-robin front end that shares one fib_step datapath between two
// requesters and returns fib(n) over a valid/ready response port.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int IDXW  = FIB_IDXW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [IDXW-1:0]  req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IDXW-1:0]  req1_n,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_ovf
);

  state_t           state;
  req_id_t          last_grant;
  req_id_t          grant_id;
  logic             grant_any;
  logic [IDXW-1:0]  remaining;
  logic [IDXW-1:0]  n_sel;
  logic             load;
  logic             step;
  logic [WIDTH-1:0] step_a;
  logic             step_ovf_a;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req0_valid) begin
      grant_id = 1'b0;
    end else begin
      grant_id = 1'b1;
    end
  end

  assign n_sel      = grant_id ? req1_n : req0_n;
  assign load       = (state == IDLE) && grant_any;
  assign step       = (state == RUN) && (remaining != '0);
  assign req0_ready = !reset && (state == IDLE) && req0_valid && (grant_id == 1'b0);
  assign req1_ready = !reset && (state == IDLE) && req1_valid && (grant_id == 1'b1);

  fib_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (step),
    .a     (step_a),
    .ovf_a (step_ovf_a)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      remaining  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_value <= '0;
      resp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            remaining  <= n_sel;
            resp_id    <= grant_id;
            last_grant <= grant_id;
            state      <= RUN;
          end
        end
        RUN: begin
          if (remaining == '0) begin
            resp_value <= step_a;
            resp_ovf   <= step_ovf_a;
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed self-checking bench for fib_sequencer with hand-computed results.
module tb_fib_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [4:0] req0_n, req1_n;
  logic       req0_ready, req1_ready;
  logic       resp_valid, resp_ready;
  logic       resp_id;
  logic [7:0] resp_value;
  logic       resp_ovf;

  int errors = 0;
  int checks = 0;

  fib_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_n     (req0_n),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_n     (req1_n),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_value (resp_value),
    .resp_ovf   (resp_ovf)
  );

  always #5 clk = ~clk;

  // Submit one request from a single requester, then report what came back.
  task automatic run_request(input logic id, input logic [4:0] n, output logic accepted,
                             output int lat, output logic rid, output logic [7:0] val,
                             output logic ovf);
    if (id) begin req1_valid = 1'b1; req1_n = n; end
    else    begin req0_valid = 1'b1; req0_n = n; end
    #1;
    accepted = id ? req1_ready : req0_ready;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rid = resp_id;
    val = resp_value;
    ovf = resp_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_n = 5'd3; req1_n = 5'd4;
    resp_ready = 1'b1;
    #2;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", resp_valid); end
    checks++; if (resp_value !== 8'd0) begin errors++; $display("[TB] FAIL reset_value got=%0d want=0", resp_value); end
    checks++; if (resp_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b want=0", resp_ovf); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_id got=%b want=0", resp_id); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got=%b want=00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL first_tie_ready got=%b want=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic acc, rid, ovf;
    logic [7:0] val;
    int lat;
    resp_ready = 1'b1;
    run_request(1'b0, 5'd10, acc, lat, rid, val, ovf);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL single_accept got=%b want=1", acc); end
    checks++; if (lat != 11) begin errors++; $display("[TB] FAIL single_latency got=%0d want=11", lat); end
    checks++; if (val !== 8'd55) begin errors++; $display("[TB] FAIL single_value got=%0d want=55", val); end
    checks++; if (rid !== 1'b0) begin errors++; $display("[TB] FAIL single_id got=%b want=0", rid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL single_ovf got=%b want=0", ovf); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse got=%b want=0", resp_valid); end
  endtask

  task automatic test_boundary();
    logic [4:0] bn[5]  = '{5'd0, 5'd1, 5'd13, 5'd14, 5'd31};
    logic [7:0] bv[5]  = '{8'd0, 8'd1, 8'd233, 8'd121, 8'd221};
    logic       bo[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic acc, rid, ovf;
    logic [7:0] val;
    int lat;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_request(1'b0, bn[i], acc, lat, rid, val, ovf);
      checks++; if (lat != int'(bn[i]) + 1) begin errors++; $display("[TB] FAIL bound_latency n=%0d got=%0d want=%0d", bn[i], lat, int'(bn[i]) + 1); end
      checks++; if (val !== bv[i]) begin errors++; $display("[TB] FAIL bound_value n=%0d got=%0d want=%0d", bn[i], val, bv[i]); end
      checks++; if (ovf !== bo[i]) begin errors++; $display("[TB] FAIL bound_ovf n=%0d got=%b want=%b", bn[i], ovf, bo[i]); end
    end
  endtask

  task automatic test_contention();
    logic       ids[4];
    logic [7:0] vals[4];
    logic       exp_id[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_val[4] = '{8'd5, 8'd8, 8'd5, 8'd8};
    int got = 0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_n = 5'd5;
    req1_valid = 1'b1; req1_n = 5'd6;
    for (int c = 0; c < 200 && got < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        ids[got]  = resp_id;
        vals[got] = resp_value;
        got++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (got != 4) begin errors++; $display("[TB] FAIL contention_count got=%0d want=4", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if (ids[i] !== exp_id[i] || vals[i] !== exp_val[i]) begin
        errors++;
        $display("[TB] FAIL contention_resp%0d got=(%b,%0d) want=(%b,%0d)", i, ids[i], vals[i], exp_id[i], exp_val[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat = 0;
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_n = 5'd12;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_arrive got=%b want=1", resp_valid); end
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++; if ({resp_valid, resp_id, resp_value, resp_ovf} !== {1'b1, 1'b1, 8'd144, 1'b0}) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d got=(%b,%b,%0d,%b) want=(1,1,144,0)", c, resp_valid, resp_id, resp_value, resp_ovf);
      end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready cycle=%0d got=%b want=00", c, {req0_ready, req1_ready}); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release got=%b want=0", resp_valid); end
  endtask

  task automatic test_reset_mid_run();
    logic acc, rid, ovf;
    logic [7:0] val;
    int lat;
    int seen = 0;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_n = 5'd20;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    req0_valid = 1'b1;
    #1;
    checks++; if ({resp_valid, resp_id, resp_value, resp_ovf} !== {1'b0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL midrun_outputs got=(%b,%b,%0d,%b) want=(0,0,0,0)", resp_valid, resp_id, resp_value, resp_ovf);
    end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrun_ready got=%b want=0", req0_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    req0_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midrun_no_resp got=%0d want=0", seen); end
    run_request(1'b0, 5'd7, acc, lat, rid, val, ovf);
    checks++; if (val !== 8'd13 || lat != 8) begin errors++; $display("[TB] FAIL midrun_resubmit got=(%0d,lat %0d) want=(13,lat 8)", val, lat); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
